// File: rtl/fft_iter_addr_gen.sv
// -----------------------------------------------------------------------------
// fft_iter_addr_gen
//
// Address generator for the iterative radix-2 FFT core. It follows the
// iterative FFT control unit: each ADDR_EN strobe moves to the next butterfly,
// and an ADDR_EN together with LAY_EN moves to the next layer. From the
// registered butterfly and layer counters it decodes the data-RAM read and
// write addresses for the butterfly's two operands, plus the twiddle-ROM index.
//
// Layer 0 reads the natural-order input buffer through bit-reversed addresses.
// Every later access is in-place and in natural order in the work buffer.
// Write addresses are always in natural order.
//
// Address decode for layer s, butterfly b (span = 2^s):
//   A  = b with a zero bit inserted at bit position s
//      = ((b >> s) << (s+1)) | (b mod span)
//   B  = A + span            (bit s of A is zero, so this is A | span)
//   TW = (b mod span) << (LAYERS-1-s)
//
// Ports:
//   CLK        in   clock, all state on posedge
//   RST        in   synchronous active-high reset
//   EN         in   clock enable for every state update
//   START      in   frame start: clears counters, DONE and SEQ_ERR
//   ADDR_EN    in   butterfly-advance strobe
//   LAY_EN     in   layer-advance strobe, only acted on together with ADDR_EN
//   FIRST      in   high during layer 0, selects bit-reversed read addresses
//   RD_ADDR_A  out  top-input read address
//   RD_ADDR_B  out  bottom-input read address
//   WR_ADDR_A  out  top-output write address
//   WR_ADDR_B  out  bottom-output write address
//   TW_ADDR    out  twiddle ROM index
//   SRC_SEL    out  read source: 0 = work buffer, 1 = input buffer
//   LAYER      out  current layer index
//   DONE       out  one-cycle pulse when the last layer is retired
//   SEQ_ERR    out  sticky sequencing-violation flag
// -----------------------------------------------------------------------------
module fft_iter_addr_gen #(
  parameter int LAYERS      = 5,
  parameter int BUTTERFLYES = 16,
  parameter int LayWL       = 3,
  parameter int ButtWL      = 4,
  parameter int AddrWL      = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              START,
  input  logic              ADDR_EN,
  input  logic              LAY_EN,
  input  logic              FIRST,
  output logic [AddrWL-1:0] RD_ADDR_A,
  output logic [AddrWL-1:0] RD_ADDR_B,
  output logic [AddrWL-1:0] WR_ADDR_A,
  output logic [AddrWL-1:0] WR_ADDR_B,
  output logic [LAYERS-2:0] TW_ADDR,
  output logic              SRC_SEL,
  output logic [LayWL-1:0]  LAYER,
  output logic              DONE,
  output logic              SEQ_ERR
);

  localparam logic [ButtWL-1:0] BUTT_LAST = ButtWL'(BUTTERFLYES - 1);
  localparam logic [LayWL-1:0]  LAY_LAST  = LayWL'(LAYERS - 1);
  localparam int                TW_WL     = LAYERS - 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ButtWL-1:0] r_butt_cnt;
  logic [LayWL-1:0]  r_lay_cnt;
  logic              r_done;
  logic              r_seq_err;

  // Next-state values
  logic [ButtWL-1:0] w_butt_nxt;
  logic [LayWL-1:0]  w_lay_nxt;
  logic              w_done_nxt;
  logic              w_seq_err_nxt;

  logic w_butt_last;
  logic w_lay_last;

  assign w_butt_last = (r_butt_cnt == BUTT_LAST);
  assign w_lay_last  = (r_lay_cnt  == LAY_LAST);

  // Next-state logic. START takes priority over ADDR_EN. LAY_EN on its own
  // is ignored.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    w_butt_nxt    = r_butt_cnt;
    w_lay_nxt     = r_lay_cnt;
    w_done_nxt    = 1'b0;
    w_seq_err_nxt = r_seq_err;

    if (START) begin
      w_butt_nxt    = '0;
      w_lay_nxt     = '0;
      w_seq_err_nxt = 1'b0;
    end else if (ADDR_EN) begin
      if (LAY_EN) begin
        w_butt_nxt = '0;
        if (w_lay_last) begin
          w_lay_nxt  = '0;
          w_done_nxt = 1'b1;
        end else begin
          w_lay_nxt = r_lay_cnt + 1'b1;
        end
        // The layer strobe arrived before the last butterfly. Still advance,
        // so that the control unit and this block stay in lockstep.
        if (!w_butt_last) begin
          w_seq_err_nxt = 1'b1;
        end
      end else begin
        if (w_butt_last) begin
          // Wrapped past the last butterfly without a layer strobe.
          w_butt_nxt    = '0;
          w_seq_err_nxt = 1'b1;
        end else begin
          w_butt_nxt = r_butt_cnt + 1'b1;
        end
      end
    end
  end

  // State register. Reset wins over EN, and EN gates every other update,
  // including the DONE pulse register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples its pre-edge value regardless of statement order.
    if (RST) begin
      r_butt_cnt <= '0;
      r_lay_cnt  <= '0;
      r_done     <= 1'b0;
      r_seq_err  <= 1'b0;
    end else if (EN) begin
      r_butt_cnt <= w_butt_nxt;
      r_lay_cnt  <= w_lay_nxt;
      r_done     <= w_done_nxt;
      r_seq_err  <= w_seq_err_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Address decode, combinational from the registered counters
  // ---------------------------------------------------------------------------
  logic [AddrWL-1:0]       w_b_ext;
  logic [AddrWL-1:0]       w_span;
  logic [AddrWL-1:0]       w_low_mask;
  logic [AddrWL-1:0]       w_addr_a;
  logic [AddrWL-1:0]       w_addr_b;
  logic [ButtWL-1:0]       w_pos;
  logic [ButtWL+TW_WL-1:0] w_tw_wide;

  always_comb begin
    w_b_ext    = AddrWL'(r_butt_cnt);
    w_span     = AddrWL'(1) << r_lay_cnt;
    w_low_mask = w_span - AddrWL'(1);
    // The bits of b at and above position s move up by one. This opens a zero
    // at bit s, which is the bit that separates the A and B operands.
    w_addr_a   = ((w_b_ext & ~w_low_mask) << 1) | (w_b_ext & w_low_mask);
    w_addr_b   = w_addr_a | w_span;
    w_pos      = r_butt_cnt & w_low_mask[ButtWL-1:0];
    // pos << (LAYERS-1-s), formed as (pos << (LAYERS-1)) >> s so that the
    // shift amount never goes negative.
    w_tw_wide  = {w_pos, {TW_WL{1'b0}}} >> r_lay_cnt;
  end

  function automatic logic [AddrWL-1:0] f_bitrev(input logic [AddrWL-1:0] x);
    logic [AddrWL-1:0] r;
    r = '0;
    for (int i = 0; i < AddrWL; i++) begin
      r[i] = x[AddrWL-1-i];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign WR_ADDR_A = w_addr_a;
  assign WR_ADDR_B = w_addr_b;
  assign RD_ADDR_A = FIRST ? f_bitrev(w_addr_a) : w_addr_a;
  assign RD_ADDR_B = FIRST ? f_bitrev(w_addr_b) : w_addr_b;
  assign TW_ADDR   = w_tw_wide[TW_WL-1:0];
  assign SRC_SEL   = FIRST;
  assign LAYER     = r_lay_cnt;
  assign DONE      = r_done;
  assign SEQ_ERR   = r_seq_err;

endmodule

// File: tb/tb_fft_iter_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_fft_iter_addr_gen
//
// Directed bench for fft_iter_addr_gen with the default parameters (32-point,
// 5 layers, 16 butterflies per layer). Inputs change 1 time unit after the
// rising edge, and outputs are sampled at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_fft_iter_addr_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       EN = 1'b0;
  logic       START = 1'b0;
  logic       ADDR_EN = 1'b0;
  logic       LAY_EN = 1'b0;
  logic       FIRST = 1'b0;
  logic [4:0] RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B;
  logic [3:0] TW_ADDR;
  logic       SRC_SEL;
  logic [2:0] LAYER;
  logic       DONE;
  logic       SEQ_ERR;

  int total = 0;
  int bad   = 0;

  fft_iter_addr_gen dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .START     (START),
    .ADDR_EN   (ADDR_EN),
    .LAY_EN    (LAY_EN),
    .FIRST     (FIRST),
    .RD_ADDR_A (RD_ADDR_A),
    .RD_ADDR_B (RD_ADDR_B),
    .WR_ADDR_A (WR_ADDR_A),
    .WR_ADDR_B (WR_ADDR_B),
    .TW_ADDR   (TW_ADDR),
    .SRC_SEL   (SRC_SEL),
    .LAYER     (LAYER),
    .DONE      (DONE),
    .SEQ_ERR   (SEQ_ERR)
  );

  always #5 CLK = ~CLK;

  // Reference model, written straight from the address formulas
  function automatic int m_addr_a(input int s, input int b);
    return ((b >> s) << (s + 1)) + (b % (1 << s));
  endfunction

  function automatic int m_tw(input int s, input int b);
    return ((b % (1 << s)) << (4 - s)) & 15;
  endfunction

  function automatic int m_rev5(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 5; i++) begin
      if (((x >> i) & 1) != 0) r = r | (1 << (4 - i));
    end
    return r;
  endfunction

  // Stimulus helpers
  task automatic step(input logic a, input logic l);
    ADDR_EN = a;
    LAY_EN  = l;
    @(posedge CLK);
    #1;
    ADDR_EN = 1'b0;
    LAY_EN  = 1'b0;
  endtask

  task automatic do_start();
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  // From START, walk legally to layer lay, butterfly b
  task automatic advance_to(input int lay, input int b);
    do_start();
    for (int l = 0; l < lay; l++) begin
      strobes(15);
      step(1'b1, 1'b1);
    end
    strobes(b);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    EN  = 1'b1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if ({LAYER, DONE, SEQ_ERR} !== {3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_flags: got layer=%0d done=%b err=%b, expected 0 0 0", LAYER, DONE, SEQ_ERR);
    end
    total++;
    if ({WR_ADDR_A, WR_ADDR_B, RD_ADDR_A, RD_ADDR_B, TW_ADDR, SRC_SEL} !== {5'd0, 5'd1, 5'd0, 5'd1, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_addr: got wa=%0d wb=%0d ra=%0d rb=%0d tw=%0d src=%b, expected 0 1 0 1 0 0",
               WR_ADDR_A, WR_ADDR_B, RD_ADDR_A, RD_ADDR_B, TW_ADDR, SRC_SEL);
    end
    RST = 1'b0;
  endtask

  task automatic test_layer0_bitrev();
    FIRST = 1'b1;
    do_start();
    strobes(3);
    total++;
    if ({WR_ADDR_A, WR_ADDR_B, RD_ADDR_A, RD_ADDR_B, TW_ADDR, SRC_SEL} !== {5'd6, 5'd7, 5'd12, 5'd28, 4'd0, 1'b1}) begin
      bad++;
      $display("FAIL layer0_b3: got wa=%0d wb=%0d ra=%0d rb=%0d tw=%0d src=%b, expected 6 7 12 28 0 1",
               WR_ADDR_A, WR_ADDR_B, RD_ADDR_A, RD_ADDR_B, TW_ADDR, SRC_SEL);
    end
  endtask

  task automatic test_layer2();
    strobes(12);              // b = 15
    step(1'b1, 1'b1);         // layer 1
    FIRST = 1'b0;
    strobes(15);
    step(1'b1, 1'b1);         // layer 2
    strobes(5);
    total++;
    if ({RD_ADDR_A, WR_ADDR_A, RD_ADDR_B, WR_ADDR_B, TW_ADDR, LAYER, SRC_SEL} !==
        {5'd9, 5'd9, 5'd13, 5'd13, 4'd4, 3'd2, 1'b0}) begin
      bad++;
      $display("FAIL layer2_b5: got ra=%0d wa=%0d rb=%0d wb=%0d tw=%0d layer=%0d src=%b, expected 9 9 13 13 4 2 0",
               RD_ADDR_A, WR_ADDR_A, RD_ADDR_B, WR_ADDR_B, TW_ADDR, LAYER, SRC_SEL);
    end
    total++;
    if (SEQ_ERR !== 1'b0) begin
      bad++;
      $display("FAIL layer2_err: got %b expected 0", SEQ_ERR);
    end
  endtask

  task automatic test_last_layer_done();
    strobes(10);
    step(1'b1, 1'b1);         // layer 3
    strobes(15);
    step(1'b1, 1'b1);         // layer 4
    strobes(15);
    total++;
    if ({WR_ADDR_A, WR_ADDR_B, RD_ADDR_A, RD_ADDR_B, TW_ADDR, LAYER, DONE} !==
        {5'd15, 5'd31, 5'd15, 5'd31, 4'd15, 3'd4, 1'b0}) begin
      bad++;
      $display("FAIL layer4_b15: got wa=%0d wb=%0d ra=%0d rb=%0d tw=%0d layer=%0d done=%b, expected 15 31 15 31 15 4 0",
               WR_ADDR_A, WR_ADDR_B, RD_ADDR_A, RD_ADDR_B, TW_ADDR, LAYER, DONE);
    end
    step(1'b1, 1'b1);         // retire the last layer
    total++;
    if ({DONE, LAYER, WR_ADDR_A, WR_ADDR_B, SEQ_ERR} !== {1'b1, 3'd0, 5'd0, 5'd1, 1'b0}) begin
      bad++;
      $display("FAIL done_pulse: got done=%b layer=%0d wa=%0d wb=%0d err=%b, expected 1 0 0 1 0",
               DONE, LAYER, WR_ADDR_A, WR_ADDR_B, SEQ_ERR);
    end
    step(1'b0, 1'b0);
    total++;
    if (DONE !== 1'b0) begin
      bad++;
      $display("FAIL done_one_cycle: got %b expected 0", DONE);
    end
  endtask

  task automatic test_full_frame();
    int done_cnt;
    int ea, eb, ra, rb;
    done_cnt = 0;
    do_start();
    for (int l = 0; l < 5; l++) begin
      FIRST = (l == 0);
      #1;
      for (int k = 0; k < 16; k++) begin
        ea = m_addr_a(l, k);
        eb = ea + (1 << l);
        ra = (l == 0) ? m_rev5(ea) : ea;
        rb = (l == 0) ? m_rev5(eb) : eb;
        total++;
        if ({WR_ADDR_A, WR_ADDR_B, RD_ADDR_A, RD_ADDR_B, TW_ADDR, LAYER} !==
            {5'(ea), 5'(eb), 5'(ra), 5'(rb), 4'(m_tw(l, k)), 3'(l)}) begin
          bad++;
          $display("FAIL frame_l%0d_b%0d: got wa=%0d wb=%0d ra=%0d rb=%0d tw=%0d layer=%0d, expected %0d %0d %0d %0d %0d %0d",
                   l, k, WR_ADDR_A, WR_ADDR_B, RD_ADDR_A, RD_ADDR_B, TW_ADDR, LAYER,
                   ea, eb, ra, rb, m_tw(l, k), l);
        end
        step(1'b1, k == 15);
        if (DONE === 1'b1) done_cnt++;
      end
    end
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL frame_done_count: got %0d expected 1", done_cnt);
    end
    total++;
    if (SEQ_ERR !== 1'b0) begin
      bad++;
      $display("FAIL frame_err: got %b expected 0", SEQ_ERR);
    end
  endtask

  task automatic test_wrap_error();
    FIRST = 1'b0;
    strobes(15);
    step(1'b1, 1'b1);         // legal move to layer 1
    strobes(15);              // b = 15
    total++;
    if (SEQ_ERR !== 1'b0) begin
      bad++;
      $display("FAIL wrap_pre_err: got %b expected 0", SEQ_ERR);
    end
    step(1'b1, 1'b0);         // 16th strobe without LAY_EN
    total++;
    if ({LAYER, WR_ADDR_A, WR_ADDR_B, SEQ_ERR} !== {3'd1, 5'd0, 5'd2, 1'b1}) begin
      bad++;
      $display("FAIL wrap: got layer=%0d wa=%0d wb=%0d err=%b, expected 1 0 2 1", LAYER, WR_ADDR_A, WR_ADDR_B, SEQ_ERR);
    end
    step(1'b1, 1'b0);
    total++;
    if ({WR_ADDR_A, SEQ_ERR} !== {5'd1, 1'b1}) begin
      bad++;
      $display("FAIL wrap_sticky: got wa=%0d err=%b, expected 1 1", WR_ADDR_A, SEQ_ERR);
    end
    do_start();
    total++;
    if ({SEQ_ERR, LAYER, WR_ADDR_A} !== {1'b0, 3'd0, 5'd0}) begin
      bad++;
      $display("FAIL start_clears: got err=%b layer=%0d wa=%0d, expected 0 0 0", SEQ_ERR, LAYER, WR_ADDR_A);
    end
    strobes(3);
    step(1'b1, 1'b1);         // early layer strobe at b = 3
    total++;
    if ({LAYER, WR_ADDR_A, WR_ADDR_B, SEQ_ERR, DONE} !== {3'd1, 5'd0, 5'd2, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL early_lay: got layer=%0d wa=%0d wb=%0d err=%b done=%b, expected 1 0 2 1 0",
               LAYER, WR_ADDR_A, WR_ADDR_B, SEQ_ERR, DONE);
    end
  endtask

  task automatic test_enable_hold_and_reset();
    advance_to(3, 7);
    total++;
    if ({WR_ADDR_A, WR_ADDR_B, TW_ADDR, LAYER, SEQ_ERR} !== {5'd7, 5'd15, 4'd14, 3'd3, 1'b0}) begin
      bad++;
      $display("FAIL l3_b7: got wa=%0d wb=%0d tw=%0d layer=%0d err=%b, expected 7 15 14 3 0",
               WR_ADDR_A, WR_ADDR_B, TW_ADDR, LAYER, SEQ_ERR);
    end
    step(1'b0, 1'b1);         // LAY_EN alone is ignored
    total++;
    if ({WR_ADDR_A, LAYER, SEQ_ERR} !== {5'd7, 3'd3, 1'b0}) begin
      bad++;
      $display("FAIL lay_only: got wa=%0d layer=%0d err=%b, expected 7 3 0", WR_ADDR_A, LAYER, SEQ_ERR);
    end
    EN = 1'b0;
    strobes(3);
    step(1'b1, 1'b1);
    do_start();
    total++;
    if ({WR_ADDR_A, WR_ADDR_B, TW_ADDR, LAYER, SEQ_ERR, DONE} !== {5'd7, 5'd15, 4'd14, 3'd3, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL en_hold: got wa=%0d wb=%0d tw=%0d layer=%0d err=%b done=%b, expected 7 15 14 3 0 0",
               WR_ADDR_A, WR_ADDR_B, TW_ADDR, LAYER, SEQ_ERR, DONE);
    end
    EN  = 1'b1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    total++;
    if ({LAYER, WR_ADDR_A, WR_ADDR_B, TW_ADDR, DONE, SEQ_ERR} !== {3'd0, 5'd0, 5'd1, 4'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset: got layer=%0d wa=%0d wb=%0d tw=%0d done=%b err=%b, expected 0 0 1 0 0 0",
               LAYER, WR_ADDR_A, WR_ADDR_B, TW_ADDR, DONE, SEQ_ERR);
    end
  endtask

  initial begin
    test_reset();
    test_layer0_bitrev();
    test_layer2();
    test_last_layer_done();
    test_full_frame();
    test_wrap_error();
    test_enable_hold_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
